// File: rtl/pwm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pwm_ctrl_pkg
//   Shared types and constants for the PWM configuration write scheduler.
//   - state_e      : commit FSM states
//   - REG_*        : register index map of the PWM configuration block
//   - *_DEF        : default sizing parameters
//   - addr_in_range: true when a requester address hits an implemented reg
// ---------------------------------------------------------------------------
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  localparam int NUM_REGS_DEF       = 5;
  localparam int ADDR_W_DEF         = 7;
  localparam int DATA_W_DEF         = 8;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  localparam int REG_EN_OUT_LO = 0;
  localparam int REG_EN_OUT_HI = 1;
  localparam int REG_EN_PWM_LO = 2;
  localparam int REG_EN_PWM_HI = 3;
  localparam int REG_DUTY      = 4;

  // Address decode helper: both operands are zero-extended to 32 bits.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] limit);
    return (addr < limit);
  endfunction

endpackage

// File: rtl/pwm_reg_commit_ctrl_if.sv
// ---------------------------------------------------------------------------
// pwm_reg_commit_ctrl_if
//   Register-write bus from the two requesters (0 = SPI, 1 = sequencer).
//   Per requester: valid, addr[ADDR_W], data[DATA_W] toward the scheduler,
//   ready back toward the requester (write accepted when valid & ready).
//   modport master : requester side
//   modport slave  : scheduler side
// ---------------------------------------------------------------------------
interface pwm_reg_commit_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) ();

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready
  );

endinterface

// File: rtl/pwm_reg_commit_ctrl_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Two-way round-robin grant for register writes.
//   Ports: clk, rst (async, active-high), req0_valid/req1_valid (requests),
//          stall (blocks all grants), req0_ready/req1_ready (combinational,
//          independent of the requester's own valid), grant0/grant1.
//   A sole valid requester is served regardless of the pointer; on contention
//   the pointer picks, and after every transfer it points at the other side.
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic req0_valid,
  input  logic req1_valid,
  input  logic stall,
  output logic req0_ready,
  output logic req1_ready,
  output logic grant0,
  output logic grant1
);

  logic rr_ptr_r;

  assign req0_ready = !stall && (!req1_valid || (rr_ptr_r == 1'b0));
  assign req1_ready = !stall && (!req0_valid || (rr_ptr_r == 1'b1));
  assign grant0     = req0_valid && req0_ready;
  assign grant1     = req1_valid && req1_ready;

  // Round-robin pointer: hand priority to the other requester after a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= 1'b0;
    end else if (grant0) begin
      rr_ptr_r <= 1'b1;
    end else if (grant1) begin
      rr_ptr_r <= 1'b0;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

endmodule

// File: rtl/pwm_reg_commit_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_reg_commit_ctrl
//   Write scheduler for the PWM configuration registers. Writes from two
//   requesters are round-robin arbitrated into a shadow set; the whole shadow
//   set is copied to the active set in one cycle (COMMIT) after a PWM period
//   boundary, so a PWM period never sees a half-applied configuration.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     bus (slave)  : requester write bus, see pwm_reg_commit_ctrl_if
//     period_tick  : 1-cycle pulse at PWM counter wrap
//     reg_out      : active registers, reg k at [k*DATA_W +: DATA_W]
//     pending      : shadow holds uncommitted writes (PENDING or COMMIT)
//     commit       : high during the COMMIT cycle
//     err_addr     : 1-cycle pulse after an accepted write to addr >= NUM_REGS
//   Optional feature macro: PWM_COMMIT_TIMEOUT_EN
//     When defined, TIMEOUT_CYCLES cycles in PENDING without a tick force a
//     commit, guarding against a stalled PWM counter.
// ---------------------------------------------------------------------------
module pwm_reg_commit_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int NUM_REGS       = NUM_REGS_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  pwm_reg_commit_ctrl_if.slave         bus,
  input  logic                         period_tick,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic                         pending,
  output logic                         commit,
  output logic                         err_addr
);

  state_e            state_r;
  logic              pending_r;
  logic              commit_r;
  logic              err_addr_r;
  logic [DATA_W-1:0] shadow_r [NUM_REGS];
  logic [DATA_W-1:0] active_r [NUM_REGS];

  logic              stall_s;
  logic              ready0_s;
  logic              ready1_s;
  logic              grant0_s;
  logic              grant1_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;
  logic              wr_in_range_s;
  logic              wr_ok_s;
  logic              commit_req_s;

  // No transfers during the commit cycle so the copied shadow set is stable.
  assign stall_s = (state_r == COMMIT);

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (bus.req0_valid),
    .req1_valid (bus.req1_valid),
    .stall      (stall_s),
    .req0_ready (ready0_s),
    .req1_ready (ready1_s),
    .grant0     (grant0_s),
    .grant1     (grant1_s)
  );

  assign bus.req0_ready = ready0_s;
  assign bus.req1_ready = ready1_s;

  // Select the granted requester's write and decode its address.
  always_comb begin
    wr_en_s   = grant0_s | grant1_s;
    wr_addr_s = '0;
    wr_data_s = '0;
    if (grant0_s) begin
      wr_addr_s = bus.req0_addr;
      wr_data_s = bus.req0_data;
    end else begin
      wr_addr_s = bus.req1_addr;
      wr_data_s = bus.req1_data;
    end
    wr_in_range_s = addr_in_range(32'(wr_addr_s), 32'(NUM_REGS));
    wr_ok_s       = wr_en_s & wr_in_range_s;
  end

`ifdef PWM_COMMIT_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt_r;

  // Cycles spent in PENDING; held at zero elsewhere so it restarts on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= '0;
    end else if (state_r == PENDING) begin
      tmo_cnt_r <= tmo_cnt_r + 1'b1;
    end else begin
      tmo_cnt_r <= '0;
    end
  end

  assign commit_req_s = period_tick | (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign commit_req_s = period_tick;
`endif

  // Commit FSM with registered pending/commit/err_addr outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      pending_r  <= 1'b0;
      commit_r   <= 1'b0;
      err_addr_r <= 1'b0;
    end else begin
      err_addr_r <= wr_en_s & ~wr_in_range_s;
      case (state_r)
        IDLE: begin
          // A tick here is ignored; only an in-range write arms a commit.
          if (wr_ok_s) begin
            state_r   <= PENDING;
            pending_r <= 1'b1;
          end else begin
            state_r   <= IDLE;
            pending_r <= 1'b0;
          end
          commit_r <= 1'b0;
        end
        PENDING: begin
          if (commit_req_s) begin
            state_r  <= COMMIT;
            commit_r <= 1'b1;
          end else begin
            state_r  <= PENDING;
            commit_r <= 1'b0;
          end
          pending_r <= 1'b1;
        end
        COMMIT: begin
          state_r   <= IDLE;
          pending_r <= 1'b0;
          commit_r  <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          pending_r <= 1'b0;
          commit_r  <= 1'b0;
        end
      endcase
    end
  end

  // Shadow set: accepted in-range writes land here; later writes overwrite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_ok_s && (wr_addr_s == ADDR_W'(k))) begin
          shadow_r[k] <= wr_data_s;
        end else begin
          shadow_r[k] <= shadow_r[k];
        end
      end
    end
  end

  // Active set: whole shadow copied at the edge closing the COMMIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        active_r[k] <= '0;
      end
    end else if (state_r == COMMIT) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        active_r[k] <= shadow_r[k];
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        active_r[k] <= active_r[k];
      end
    end
  end

  // Flatten the active set onto the output bus.
  always_comb begin
    reg_out = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      reg_out[k*DATA_W +: DATA_W] = active_r[k];
    end
  end

  assign pending  = pending_r;
  assign commit   = commit_r;
  assign err_addr = err_addr_r;

endmodule

// File: tb/tb_pwm_reg_commit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwm_reg_commit_ctrl
//   Directed bench for pwm_reg_commit_ctrl: a cycle-by-cycle vector table for
//   arbitration, commit timing and address errors, then hand-written
//   sequences for async reset, a long wait without tick, and the timeout
//   behaviour (PWM_COMMIT_TIMEOUT_EN selects which variant is expected).
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   on the falling edge.
// ---------------------------------------------------------------------------
module tb_pwm_reg_commit_ctrl;

`ifdef PWM_COMMIT_TIMEOUT_EN
  localparam int TB_TMO = 16;
`else
  localparam int TB_TMO = 4096;
`endif

  logic        clk;
  logic        rst;
  logic        tick;
  logic [39:0] reg_out;
  logic        pending;
  logic        commit;
  logic        err_addr;

  int n_checks;
  int n_fail;

  pwm_reg_commit_ctrl_if #(.ADDR_W(7), .DATA_W(8)) bus ();

  pwm_reg_commit_ctrl #(
    .NUM_REGS       (5),
    .ADDR_W         (7),
    .DATA_W         (8),
    .TIMEOUT_CYCLES (TB_TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .period_tick (tick),
    .reg_out     (reg_out),
    .pending     (pending),
    .commit      (commit),
    .err_addr    (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [6:0] a0;
    logic [7:0] d0;
    logic       v1;
    logic [6:0] a1;
    logic [7:0] d1;
    logic       tk;
    logic       r0;
    logic       r1;
    logic       pend;
    logic       com;
    logic       err;
    logic [39:0] regs;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_addr = 7'd0; bus.req0_data = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_addr = 7'd0; bus.req1_data = 8'h00;
    tick = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [39:0] r0v;
    logic [39:0] r1v;
    logic [39:0] r2v;
    int bad;
    int n;
    logic found;

    n_checks = 0;
    n_fail   = 0;
    r0v = 40'h0000AA0000;
    r1v = 40'h0000AA5522;
    r2v = 40'h803CAA5522;

    //            v0   a0     d0     v1   a1     d1     tk   | r0   r1   pend com  err  regs
    vecs[0]  = '{1'b1,7'd2,8'hAA, 1'b0,7'd0,8'h00, 1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,40'h0};
    vecs[1]  = '{1'b0,7'd0,8'h00, 1'b0,7'd0,8'h00, 1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,40'h0};
    vecs[2]  = '{1'b0,7'd0,8'h00, 1'b0,7'd0,8'h00, 1'b1, 1'b1,1'b1,1'b1,1'b0,1'b0,40'h0};
    vecs[3]  = '{1'b0,7'd0,8'h00, 1'b0,7'd0,8'h00, 1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,40'h0};
    vecs[4]  = '{1'b0,7'd0,8'h00, 1'b1,7'd5,8'h33, 1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,r0v};
    vecs[5]  = '{1'b0,7'd0,8'h00, 1'b0,7'd0,8'h00, 1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,r0v};
    vecs[6]  = '{1'b1,7'd0,8'h11, 1'b1,7'd0,8'h22, 1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,r0v};
    vecs[7]  = '{1'b1,7'd1,8'h55, 1'b1,7'd0,8'h22, 1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,r0v};
    vecs[8]  = '{1'b1,7'd1,8'h55, 1'b0,7'd0,8'h00, 1'b1, 1'b1,1'b0,1'b1,1'b0,1'b0,r0v};
    vecs[9]  = '{1'b1,7'd4,8'h80, 1'b0,7'd0,8'h00, 1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,r0v};
    vecs[10] = '{1'b1,7'd4,8'h80, 1'b0,7'd0,8'h00, 1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0,r1v};
    vecs[11] = '{1'b0,7'd0,8'h00, 1'b0,7'd0,8'h00, 1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,r1v};
    vecs[12] = '{1'b1,7'd3,8'h3C, 1'b0,7'd0,8'h00, 1'b1, 1'b1,1'b1,1'b1,1'b0,1'b0,r1v};
    vecs[13] = '{1'b0,7'd0,8'h00, 1'b0,7'd0,8'h00, 1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,r1v};
    vecs[14] = '{1'b0,7'd0,8'h00, 1'b1,7'd2,8'hAA, 1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,r2v};
    vecs[15] = '{1'b0,7'd0,8'h00, 1'b0,7'd0,8'h00, 1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,r2v};

    idle_inputs();
    rst = 1'b1;
    repeat (3) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_reg_out", 64'(reg_out), 64'h0);
    chk("reset_pending", 64'(pending), 64'h0);
    chk("reset_commit",  64'(commit),  64'h0);
    next_cycle();

    // Vector table: inputs for one cycle, outputs seen before its closing edge.
    for (int i = 0; i < 16; i++) begin
      bus.req0_valid = vecs[i].v0; bus.req0_addr = vecs[i].a0; bus.req0_data = vecs[i].d0;
      bus.req1_valid = vecs[i].v1; bus.req1_addr = vecs[i].a1; bus.req1_data = vecs[i].d1;
      tick = vecs[i].tk;
      @(negedge clk);
      chk($sformatf("row%0d_ready0", i),  64'(bus.req0_ready), 64'(vecs[i].r0));
      chk($sformatf("row%0d_ready1", i),  64'(bus.req1_ready), 64'(vecs[i].r1));
      chk($sformatf("row%0d_pending", i), 64'(pending),        64'(vecs[i].pend));
      chk($sformatf("row%0d_commit", i),  64'(commit),         64'(vecs[i].com));
      chk($sformatf("row%0d_err_addr", i), 64'(err_addr),      64'(vecs[i].err));
      chk($sformatf("row%0d_reg_out", i), 64'(reg_out),        64'(vecs[i].regs));
      next_cycle();
    end
    idle_inputs();

    // Async reset in the middle of PENDING with a non-zero active set.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_reg_out",  64'(reg_out),  64'h0);
    chk("async_rst_pending",  64'(pending),  64'h0);
    chk("async_rst_commit",   64'(commit),   64'h0);
    chk("async_rst_err_addr", 64'(err_addr), 64'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready0", 64'(bus.req0_ready), 64'h1);
    chk("post_rst_ready1", 64'(bus.req1_ready), 64'h1);
    next_cycle();
    tick = 1'b1;
    next_cycle();
    tick = 1'b0;
    @(negedge clk);
    chk("post_rst_tick_commit",  64'(commit),  64'h0);
    chk("post_rst_tick_reg_out", 64'(reg_out), 64'h0);

    // Long wait without tick: shadow stays uncommitted.
    next_cycle();
    bus.req0_valid = 1'b1; bus.req0_addr = 7'd2; bus.req0_data = 8'hAA;
    next_cycle();
    idle_inputs();
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (pending !== 1'b1 || reg_out !== 40'h0 || commit !== 1'b0) bad++;
    end
    chk("hold50_bad_cycles", 64'(bad), 64'h0);
    next_cycle();
    tick = 1'b1;
    next_cycle();
    tick = 1'b0;
    @(negedge clk);
    chk("hold50_commit", 64'(commit), 64'h1);
    chk("hold50_reg_out_before", 64'(reg_out), 64'h0);
    next_cycle();
    @(negedge clk);
    chk("hold50_reg_out_after", 64'(reg_out), 64'h0000AA0000);
    chk("hold50_pending_after", 64'(pending), 64'h0);

    // Missing tick: forced commit only with the timeout feature.
    next_cycle();
    bus.req1_valid = 1'b1; bus.req1_addr = 7'd4; bus.req1_data = 8'h80;
    next_cycle();
    idle_inputs();
`ifdef PWM_COMMIT_TIMEOUT_EN
    n = 0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (commit === 1'b1) begin
        found = 1'b1;
        break;
      end
      n++;
    end
    chk("timeout_commit_seen", 64'(found), 64'h1);
    chk("timeout_pending_cycles", 64'(n), 64'd16);
    next_cycle();
`else
    n = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (commit === 1'b1) n++;
    end
    chk("no_timeout_commits", 64'(n), 64'h0);
    chk("no_timeout_pending", 64'(pending), 64'h1);
    chk("no_timeout_reg_out", 64'(reg_out), 64'h0000AA0000);
    next_cycle();
    tick = 1'b1;
    next_cycle();
    tick = 1'b0;
    next_cycle();
`endif
    @(negedge clk);
    chk("final_reg_out", 64'(reg_out), 64'h8000AA0000);
    chk("final_pending", 64'(pending), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
